// File: rtl/fsm_seq_pkg.sv
// fsm_seq_pkg: shared state encoding and default sizing for the launch sequencer
package fsm_seq_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_e;
  localparam int DEPTH_DEF       = 4;
  localparam int REP_W_DEF       = 4;
  localparam int CNT_W_DEF       = 16;
  localparam int TIMEOUT_CYC_DEF = 64;
endpackage

// File: rtl/seq_fifo.sv
// seq_fifo: synchronous DEPTH x W job FIFO with full/empty flags and async reset
module seq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         empty_nxt_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;
  assign full_o      = cnt_q == (AW+1)'(DEPTH);
  assign empty_o     = cnt_q == '0;
  assign do_push     = push_i && !full_o;
  assign do_pop      = pop_i && !empty_o;
  assign cnt_d       = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign empty_nxt_o = cnt_d == '0;
  assign data_o      = mem_q[rd_q];
  // pointers and occupancy; full only clears the cycle after a pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= do_push ? wr_q + AW'(1) : wr_q;
      rd_q  <= do_pop ? rd_q + AW'(1) : rd_q;
      cnt_q <= cnt_d;
    end
  end
  // storage needs no reset: entries are only read once written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/fsm_launch_sequencer.sv
// fsm_launch_sequencer: queues jobs and runs start/done handshakes; FSM_SEQ_TIMEOUT_EN adds a WAIT watchdog
module fsm_launch_sequencer
  import fsm_seq_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int REP_W       = REP_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [REP_W-1:0] req_reps,
  output logic             start,
  input  logic             done,
  output logic             busy,
  output logic             job_done,
  output logic [CNT_W-1:0] jobs_completed,
  output logic             timeout_err
);
  state_e           state_q, state_d;
  logic [REP_W-1:0] rem_q, rem_d, head;
  logic [CNT_W-1:0] jc_q;
  logic             start_q, busy_q, job_done_q;
  logic             full, empty, empty_nxt, pop, fin, expire;
  assign req_ready      = !full && !reset;
  assign pop            = state_q == IDLE && !empty;
  assign fin            = state_q == WAIT && done && rem_q == REP_W'(1);
  assign start          = start_q;
  assign busy           = busy_q;
  assign job_done       = job_done_q;
  assign jobs_completed = jc_q;
  seq_fifo #(.DEPTH(DEPTH), .W(REP_W)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (req_valid && req_ready),
    .pop_i       (pop),
    .data_i      (req_reps),
    .data_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .empty_nxt_o (empty_nxt)
  );
`ifdef FSM_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wd_q;
  logic          terr_q;
  assign expire      = state_q == WAIT && !done && wd_q == TW'(TIMEOUT_CYC - 1);
  assign timeout_err = terr_q;
  // watchdog counts WAIT cycles from zero on each entry; error is sticky
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q   <= '0;
      terr_q <= 1'b0;
    end else begin
      wd_q   <= state_q == WAIT ? wd_q + TW'(1) : '0;
      terr_q <= terr_q || expire;
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif
  // next state and repeat counter; done matters only in WAIT
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: if (!empty) begin
        state_d = LAUNCH;
        rem_d   = head == '0 ? REP_W'(1) : head;
      end
      LAUNCH: state_d = WAIT;
      WAIT: if (done) begin
        state_d = rem_q == REP_W'(1) ? IDLE : GAP;
        rem_d   = rem_q - REP_W'(1);
      end else if (expire) state_d = IDLE;
      GAP: state_d = LAUNCH;
    endcase
  end
  // state plus registered outputs so start/busy/job_done never glitch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      job_done_q <= 1'b0;
      jc_q       <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      start_q    <= state_d == LAUNCH;
      busy_q     <= state_d != IDLE || !empty_nxt;
      job_done_q <= fin;
      jc_q       <= jc_q + CNT_W'(fin);
    end
  end
endmodule

// File: tb/tb_fsm_launch_sequencer.sv
// tb_fsm_launch_sequencer: directed scoreboard bench for the launch sequencer
module tb_fsm_launch_sequencer;
  logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0, done = 1'b0;
  logic [3:0]  req_reps = '0;
  logic        req_ready, start, busy, job_done, timeout_err;
  logic [15:0] jobs_completed;
  localparam int K_START = 0, K_JD = 1;
  localparam int W_JC = 0, W_BUSY = 1, W_READY = 2, W_TERR = 3, W_START = 4;
  typedef struct {int kind; int c;} ev_t;
  typedef struct {int what; int c; int val;} st_t;
  ev_t evq[$];
  st_t stq[$];
  int  cyc = 0, n_chk = 0, n_fail = 0;
  bit  fin = 0, fin_done = 0;

  fsm_launch_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_reps(req_reps), .start(start), .done(done), .busy(busy),
    .job_done(job_done), .jobs_completed(jobs_completed), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(int k);
    return k == K_START ? "start" : "job_done";
  endfunction
  function automatic string wname(int w);
    return w == W_JC ? "jobs_completed" : w == W_BUSY ? "busy" : w == W_READY ? "req_ready" :
           w == W_TERR ? "timeout_err" : "start_level";
  endfunction
  function automatic int actual(int w);
    return w == W_JC ? int'(jobs_completed) : w == W_BUSY ? int'(busy) :
           w == W_READY ? int'(req_ready) : w == W_TERR ? int'(timeout_err) : int'(start);
  endfunction

  task automatic ev_chk(input int k);
    ev_t e;
    n_chk++;
    if (evq.size() == 0) begin
      n_fail++;
      $display("FAIL %s: seen at cycle %0d, none required", kname(k), cyc);
    end else begin
      e = evq.pop_front();
      if (e.kind != k || e.c != cyc) begin
        n_fail++;
        $display("FAIL %s: seen at cycle %0d, required %s at cycle %0d", kname(k), cyc, kname(e.kind), e.c);
      end
    end
  endtask

  // monitor: retire overdue events, match observed pulses, then status checks
  always @(negedge clk) begin
    while (evq.size() > 0 && evq[0].c < cyc) begin
      ev_t e;
      e = evq.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s: missing, required at cycle %0d (now %0d)", kname(e.kind), e.c, cyc);
    end
    if (start) ev_chk(K_START);
    if (job_done) ev_chk(K_JD);
    while (stq.size() > 0 && stq[0].c <= cyc) begin
      st_t s;
      s = stq.pop_front();
      n_chk++;
      if (actual(s.what) != s.val) begin
        n_fail++;
        $display("FAIL %s @cycle %0d: got %0d, required %0d", wname(s.what), cyc, actual(s.what), s.val);
      end
    end
    if (fin && !fin_done) begin
      fin_done = 1;
      n_chk++;
      if (evq.size() != 0) begin
        n_fail++;
        $display("FAIL drain: %0d expected events never seen, required 0", evq.size());
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic exp_ev(input int k, input int c);
    evq.push_back('{kind: k, c: c});
  endtask
  task automatic exp_st(input int w, input int v);
    stq.push_back('{what: w, c: cyc, val: v});
  endtask

  initial begin
    int t, d;
    tick();
    exp_st(W_BUSY, 0); exp_st(W_JC, 0); exp_st(W_READY, 0); exp_st(W_START, 0); exp_st(W_TERR, 0);
    tick();
    reset = 1'b0;
    // single job, done 5 cycles after start
    t = cyc;
    req_valid = 1; req_reps = 1;
    exp_st(W_READY, 1); exp_ev(K_START, t + 2); exp_ev(K_JD, t + 8);
    tick(); req_valid = 0;
    tick(2); exp_st(W_BUSY, 1);
    tick(4); done = 1;
    tick(); done = 0; exp_st(W_JC, 1); exp_st(W_BUSY, 0);
    tick(2);
    // three runs with GAP between them
    t = cyc;
    req_valid = 1; req_reps = 3;
    exp_ev(K_START, t + 2); exp_ev(K_START, t + 6); exp_ev(K_START, t + 10); exp_ev(K_JD, t + 13);
    tick(); req_valid = 0;
    tick(3); done = 1; tick(); done = 0;
    tick(3); done = 1; tick(); done = 0;
    tick(3); done = 1; tick(); done = 0;
    exp_st(W_JC, 2);
    tick(2);
    // zero reps behaves as one
    t = cyc;
    req_valid = 1; req_reps = 0;
    exp_ev(K_START, t + 2); exp_ev(K_JD, t + 4);
    tick(); req_valid = 0;
    tick(2); done = 1;
    tick(); done = 0; exp_st(W_JC, 3);
    tick(4);
    // fill: 1 in flight + 4 queued, then refused; drain with done held high
    t = cyc;
    req_valid = 1; req_reps = 1;
    exp_ev(K_START, t + 2);
    for (int i = 0; i < 5; i++) begin
      exp_st(W_READY, 1);
      tick();
    end
    exp_st(W_READY, 0); exp_st(W_BUSY, 1); exp_st(W_JC, 3);
    tick(); exp_st(W_READY, 0); req_valid = 0;
    tick(2);
    d = cyc; done = 1;
    exp_ev(K_JD, d + 1);
    for (int j = 0; j < 4; j++) begin
      exp_ev(K_START, d + 2 + 3 * j);
      exp_ev(K_JD, d + 4 + 3 * j);
    end
    tick(13); done = 0;
    exp_st(W_JC, 8); exp_st(W_BUSY, 0); exp_st(W_READY, 1);
    tick(2);
    // reset while in WAIT with two jobs queued
    t = cyc;
    req_valid = 1; req_reps = 1;
    exp_ev(K_START, t + 2);
    tick(3); req_valid = 0;
    tick(); reset = 1;
    #1;
    exp_st(W_START, 0); exp_st(W_BUSY, 0); exp_st(W_READY, 0); exp_st(W_JC, 0);
    tick(2); reset = 0;
    exp_st(W_BUSY, 0); exp_st(W_READY, 1); exp_st(W_JC, 0);
    tick(2);
    t = cyc;
    req_valid = 1; req_reps = 1;
    exp_ev(K_START, t + 2); exp_ev(K_JD, t + 5);
    tick(); req_valid = 0;
    tick(3); done = 1;
    tick(); done = 0; exp_st(W_JC, 1);
    tick(2);
`ifdef FSM_SEQ_TIMEOUT_EN
    // watchdog aborts the first job, the queued one then runs
    t = cyc;
    req_valid = 1; req_reps = 1;
    exp_ev(K_START, t + 2);
    tick(2); req_valid = 0;
    tick(64); exp_st(W_TERR, 0);
    tick(); exp_st(W_TERR, 1);
    exp_ev(K_START, t + 68); exp_ev(K_JD, t + 70);
    tick(2); done = 1;
    tick(); done = 0; exp_st(W_JC, 2); exp_st(W_TERR, 1);
    tick(2);
`else
    exp_st(W_TERR, 0);
`endif
    tick(3);
    fin = 1;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
